// File: rtl/pixel_scan_collector_pkg.sv
// rtl/pixel_scan_collector_pkg.sv - shared constants and FSM state type for the pixel scan collector
package pixel_scan_collector_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int CORDW         = 10;
  localparam int LATENCY       = 160;
  localparam int FIFO_DEPTH    = 256;
  localparam int ADDR_W        = 19;
  localparam int RGB_W         = 24;
  localparam int ENTRY_W       = ADDR_W + RGB_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - synchronous result FIFO with registered occupancy count
module pix_fifo
  import pixel_scan_collector_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = ENTRY_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign count_o = count_q;
  // Head reads as zero while empty so the write bus is clean after reset.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // The upstream credit scheme must never push into a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full && !pop_i));

endmodule

// File: rtl/pixel_scan_collector.sv
// rtl/pixel_scan_collector.sv - raster scan issuer with fixed-latency result capture and frame-buffer writer
module pixel_scan_collector
  import pixel_scan_collector_pkg::*;
#(
  parameter int SCREEN_WIDTH  = pixel_scan_collector_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = pixel_scan_collector_pkg::SCREEN_HEIGHT,
  parameter int CORDW         = pixel_scan_collector_pkg::CORDW,
  parameter int LATENCY       = pixel_scan_collector_pkg::LATENCY,
  parameter int FIFO_DEPTH    = pixel_scan_collector_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [CORDW-1:0]  o_pixel_x,
  output logic [CORDW-1:0]  o_pixel_y,
  input  logic [7:0]        i_red,
  input  logic [7:0]        i_green,
  input  logic [7:0]        i_blue,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RGB_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  scan_state_e       state_q, state_d;
  logic              issue;
  logic              last_pix;
  logic              sr_exit;
  logic [CORDW-1:0]  x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sr_valid_q [LATENCY];
  logic [ADDR_W-1:0] sr_addr_q  [LATENCY];
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W:0]    occupancy;

  assign last_pix  = (x_q == CORDW'(SCREEN_WIDTH - 1)) && (y_q == CORDW'(SCREEN_HEIGHT - 1));
  assign sr_exit   = sr_valid_q[LATENCY-1];
  // A slot is reserved in the FIFO for every pixel still inside the raymarcher.
  assign occupancy = (CNT_W+1)'(in_flight_q) + (CNT_W+1)'(fifo_count);
  assign o_pixel_x = x_q;
  assign o_pixel_y = y_q;
  assign wr_valid  = !fifo_empty;
  assign wr_addr   = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign wr_data   = fifo_head[RGB_W-1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: if (issue && last_pix) state_d = ST_DRAIN;
      ST_DRAIN: if (frame_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: issue gating, busy and the end-of-frame pulse.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    issue      = (state_q == ST_ISSUE) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    frame_done = (state_q == ST_DRAIN) && (in_flight_q == '0) &&
                 (fifo_count == CNT_W'(1)) && wr_valid && wr_ready;
  end

  // Raster position and linear address advance together on each issue.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (issue) begin
      if (x_q == CORDW'(SCREEN_WIDTH - 1)) begin
        x_d = '0;
        y_d = (y_q == CORDW'(SCREEN_HEIGHT - 1)) ? '0 : y_q + CORDW'(1);
      end else begin
        x_d = x_q + CORDW'(1);
      end
      addr_d = last_pix ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // Raster position registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  // Valid bits of the latency-matching pipe; cleared on reset to drop in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) sr_valid_q[i] <= 1'b0;
    end else begin
      sr_valid_q[0] <= issue;
      for (int i = 1; i < LATENCY; i++) sr_valid_q[i] <= sr_valid_q[i-1];
    end
  end

  // Address side of the latency-matching pipe.
  always_ff @(posedge clk) begin
    sr_addr_q[0] <= addr_q;
    for (int i = 1; i < LATENCY; i++) sr_addr_q[i] <= sr_addr_q[i-1];
  end

  // Count of pixels issued but not yet captured from the raymarcher.
  always_comb begin
    case ({issue, sr_exit})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  // In-flight counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) in_flight_q <= '0;
    else        in_flight_q <= in_flight_d;
  end

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_pix_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (sr_exit),
    .push_data_i ({sr_addr_q[LATENCY-1], i_red, i_green, i_blue}),
    .pop_i       (wr_valid && wr_ready),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

endmodule
